// File: rtl/riscv_irq_requester_pkg.sv
// Shared constants, FSM state type and helpers for the interrupt requester.
package riscv_irq_requester_pkg;

   localparam int IRQ_ID_WIDTH = 5;
   localparam int IRQ_NUM      = 32;

   typedef enum logic [1:0] {
      IRQ_REQ_IDLE,
      IRQ_REQ_REQ,
      IRQ_REQ_GAP
   } irq_req_state_t;

   function automatic logic [IRQ_NUM-1:0] irq_onehot(input logic [IRQ_ID_WIDTH-1:0] id);
      logic [IRQ_NUM-1:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/riscv_irq_requester_prio_enc.sv
// Fixed-priority encoder: reports the highest set index of a 32-bit request vector.
module riscv_irq_prio_enc
   import riscv_irq_requester_pkg::*;
(
   input  logic [IRQ_NUM-1:0]      req,
   output logic [IRQ_ID_WIDTH-1:0] id,
   output logic                    valid
);

   // Ascending scan so the last hit (highest index) wins.
   always_comb begin
      id = '0;
      for (int i = 0; i < IRQ_NUM; i++) begin
         if (req[i]) id = IRQ_ID_WIDTH'(i);
      end
   end

   assign valid = |req;

endmodule

// File: rtl/riscv_irq_requester.sv
// Event-unit interrupt requester: pending capture, fixed-priority request, ack handshake.
// Optional macro RISCV_IRQ_REARB_EN lets a higher-priority line replace the id while requesting.
module riscv_irq_requester
   import riscv_irq_requester_pkg::*;
#(
   parameter int PULP_SECURE = 0,
   parameter int NUM_IRQ     = IRQ_NUM
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IRQ-1:0]      event_i,
   input  logic [NUM_IRQ-1:0]      irq_enable_i,
   input  logic [NUM_IRQ-1:0]      irq_sec_mask_i,
   input  logic                    irq_ack_i,
   input  logic [IRQ_ID_WIDTH-1:0] irq_ack_id_i,
   output logic                    irq_o,
   output logic [IRQ_ID_WIDTH-1:0] irq_id_o,
   output logic                    irq_sec_o,
   output logic [NUM_IRQ-1:0]      pending_o,
   output logic                    ack_mismatch_o
);

   irq_req_state_t          state;
   logic [NUM_IRQ-1:0]      cand;
   logic [NUM_IRQ-1:0]      ack_clr;
   logic [IRQ_ID_WIDTH-1:0] winner;
   logic                    cand_valid;
   logic                    sec_win;

   assign ack_clr = irq_ack_i ? irq_onehot(irq_ack_id_i) : '0;
   assign cand    = pending_o & irq_enable_i;

   riscv_irq_prio_enc u_prio_enc (
      .req   (cand),
      .id    (winner),
      .valid (cand_valid)
   );

   generate
      if (PULP_SECURE != 0) begin : g_sec
         assign sec_win = irq_sec_mask_i[winner];
      end else begin : g_nosec
         logic unused_sec;
         assign unused_sec = ^irq_sec_mask_i;
         assign sec_win    = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_o      <= '0;
         state          <= IRQ_REQ_IDLE;
         irq_o          <= 1'b0;
         irq_id_o       <= '0;
         irq_sec_o      <= 1'b0;
         ack_mismatch_o <= 1'b0;
      end else begin
         // A new event on the acked line survives the clear.
         pending_o      <= (pending_o & ~ack_clr) | event_i;
         ack_mismatch_o <= irq_ack_i &&
                           ((state != IRQ_REQ_REQ) || (irq_ack_id_i != irq_id_o));
         case (state)
            IRQ_REQ_IDLE: begin
               if (cand_valid) begin
                  state     <= IRQ_REQ_REQ;
                  irq_o     <= 1'b1;
                  irq_id_o  <= winner;
                  irq_sec_o <= sec_win;
               end
            end
            IRQ_REQ_REQ: begin
               if (irq_ack_i) begin
                  state     <= IRQ_REQ_GAP;
                  irq_o     <= 1'b0;
                  irq_sec_o <= 1'b0;
               end else if (!cand[irq_id_o]) begin
                  // Enable dropped under us: withdraw but keep the line pending.
                  state     <= IRQ_REQ_IDLE;
                  irq_o     <= 1'b0;
                  irq_sec_o <= 1'b0;
               end
`ifdef RISCV_IRQ_REARB_EN
               else if (winner > irq_id_o) begin
                  irq_id_o  <= winner;
                  irq_sec_o <= sec_win;
               end
`endif
            end
            IRQ_REQ_GAP: begin
               state     <= IRQ_REQ_IDLE;
               irq_sec_o <= 1'b0;
            end
            default: begin
               state <= IRQ_REQ_IDLE;
               irq_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_irq_requester.sv
// Self-checking bench for riscv_irq_requester: directed scenarios plus randomized model compare.
module tb_riscv_irq_requester;

   localparam bit SEC = 1'b1;
`ifdef RISCV_IRQ_REARB_EN
   localparam bit REARB = 1'b1;
`else
   localparam bit REARB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ev, en, sm;
   logic        ack;
   logic [4:0]  ack_id;
   logic        irq, irq_sec, mis;
   logic [4:0]  irq_id;
   logic [31:0] pend;

   int nchk = 0;
   int nerr = 0;

   riscv_irq_requester #(.PULP_SECURE(1), .NUM_IRQ(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .event_i        (ev),
      .irq_enable_i   (en),
      .irq_sec_mask_i (sm),
      .irq_ack_i      (ack),
      .irq_ack_id_i   (ack_id),
      .irq_o          (irq),
      .irq_id_o       (irq_id),
      .irq_sec_o      (irq_sec),
      .pending_o      (pend),
      .ack_mismatch_o (mis)
   );

   always #5 clk = ~clk;

   // Reference model: request is "active" while m_irq, then one blank cycle (m_gap).
   bit [31:0] m_pend;
   bit        m_irq, m_gap, m_sec, m_mis;
   bit [4:0]  m_id;
   bit [31:0] m_cand, m_np;
   int        m_win;

   always @(posedge clk) begin
      m_cand = m_pend & en;
      m_win  = -1;
      for (int i = 0; i < 32; i++) if (m_cand[i]) m_win = i;
      m_np = m_pend;
      if (ack) m_np[ack_id] = 1'b0;
      m_np = m_np | ev;
      if (rst) begin
         m_pend = 0; m_irq = 0; m_gap = 0; m_sec = 0; m_mis = 0; m_id = 0;
      end else begin
         m_mis = ack && !(m_irq && ack_id == m_id);
         if (m_irq) begin
            if (ack) begin
               m_irq = 0; m_gap = 1; m_sec = 0;
            end else if (!m_cand[m_id]) begin
               m_irq = 0; m_sec = 0;
            end else if (REARB && m_win > int'(m_id)) begin
               m_id  = 5'(m_win);
               m_sec = SEC & sm[m_win];
            end
         end else if (m_gap) begin
            m_gap = 0;
         end else if (m_win >= 0) begin
            m_irq = 1;
            m_id  = 5'(m_win);
            m_sec = SEC & sm[m_win];
         end
         m_pend = m_np;
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1; ev = 0; en = '1; sm = 0; ack = 0; ack_id = 0;
      tick(); tick();
      rst = 0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1; ev = '1; en = '1; sm = '1; ack = 1; ack_id = 5'd3;
      tick();
      nchk++;
      if (irq !== 0 || irq_id !== 0 || irq_sec !== 0 || pend !== 0 || mis !== 0) begin
         nerr++;
         $display("FAIL reset_state: irq=%0b id=%0d sec=%0b pend=%h mis=%0b, want all 0",
                  irq, irq_id, irq_sec, pend, mis);
      end
      rst = 0; ev = 0; ack = 0; sm = 0;
      tick();
      nchk++;
      if (pend !== 0 || irq !== 0) begin
         nerr++;
         $display("FAIL reset_release: pend=%h irq=%0b, want 0 0", pend, irq);
      end
   endtask

   task automatic test_basic();
      do_reset();
      ev = 32'h20; tick(); ev = 0;             // cycle 1
      nchk++;
      if (pend !== 32'h20 || irq !== 0) begin
         nerr++; $display("FAIL basic_pending: pend=%h irq=%0b, want 20 0", pend, irq);
      end
      tick();                                   // cycle 2
      nchk++;
      if (irq !== 1 || irq_id !== 5'd5) begin
         nerr++; $display("FAIL basic_req: irq=%0b id=%0d, want 1 5", irq, irq_id);
      end
      tick(); tick();                           // cycle 4
      ack = 1; ack_id = 5'd5; tick(); ack = 0;  // cycle 5
      nchk++;
      if (irq !== 0 || pend !== 0 || mis !== 0) begin
         nerr++; $display("FAIL basic_ack: irq=%0b pend=%h mis=%0b, want 0 0 0", irq, pend, mis);
      end
      tick();                                   // cycle 6
      nchk++;
      if (irq !== 0) begin
         nerr++; $display("FAIL basic_gap: irq=%0b, want 0", irq);
      end
   endtask

   task automatic test_priority();
      do_reset();
      ev = (32'h1 << 3) | (32'h1 << 17); tick(); ev = 0;
      tick();
      nchk++;
      if (irq !== 1 || irq_id !== 5'd17) begin
         nerr++; $display("FAIL prio_first: irq=%0b id=%0d, want 1 17", irq, irq_id);
      end
      ack = 1; ack_id = 5'd17; tick(); ack = 0;
      tick();
      nchk++;
      if (irq !== 0) begin
         nerr++; $display("FAIL prio_gap: irq=%0b, want 0", irq);
      end
      tick();
      nchk++;
      if (irq !== 1 || irq_id !== 5'd3) begin
         nerr++; $display("FAIL prio_second: irq=%0b id=%0d, want 1 3", irq, irq_id);
      end
   endtask

   task automatic test_rearb();
      do_reset();
      ev = 32'h1 << 3; tick(); ev = 0;
      tick();
      ev = 32'h1 << 20; tick(); ev = 0;
      tick();
      nchk++;
      if (irq !== 1 || irq_id !== (REARB ? 5'd20 : 5'd3)) begin
         nerr++; $display("FAIL rearb_id: irq=%0b id=%0d, want 1 %0d", irq, irq_id, REARB ? 20 : 3);
      end
      tick();
      nchk++;
      if (irq !== 1 || irq_id !== (REARB ? 5'd20 : 5'd3)) begin
         nerr++; $display("FAIL rearb_hold: irq=%0b id=%0d", irq, irq_id);
      end
      ack = 1; ack_id = irq_id; tick(); ack = 0;
      tick(); tick();
      nchk++;
      if (irq !== 1 || irq_id !== (REARB ? 5'd3 : 5'd20)) begin
         nerr++; $display("FAIL rearb_next: irq=%0b id=%0d, want 1 %0d", irq, irq_id, REARB ? 3 : 20);
      end
   endtask

   task automatic test_withdraw();
      do_reset();
      ev = 32'h1 << 9; tick(); ev = 0;
      tick();
      en[9] = 1'b0; tick();
      nchk++;
      if (irq !== 0 || pend[9] !== 1'b1) begin
         nerr++; $display("FAIL withdraw: irq=%0b pend9=%0b, want 0 1", irq, pend[9]);
      end
      en[9] = 1'b1; tick();
      nchk++;
      if (irq !== 1 || irq_id !== 5'd9) begin
         nerr++; $display("FAIL withdraw_reissue: irq=%0b id=%0d, want 1 9", irq, irq_id);
      end
   endtask

   task automatic test_mismatch();
      do_reset();
      ev = (32'h1 << 4) | (32'h1 << 7); tick(); ev = 0;
      tick();
      ack = 1; ack_id = 5'd4; tick(); ack = 0;
      nchk++;
      if (mis !== 1 || pend[4] !== 0 || pend[7] !== 1 || irq !== 0) begin
         nerr++; $display("FAIL mismatch_pulse: mis=%0b p4=%0b p7=%0b irq=%0b, want 1 0 1 0",
                          mis, pend[4], pend[7], irq);
      end
      tick();
      nchk++;
      if (mis !== 0 || irq !== 0) begin
         nerr++; $display("FAIL mismatch_once: mis=%0b irq=%0b, want 0 0", mis, irq);
      end
      tick();
      nchk++;
      if (irq !== 1 || irq_id !== 5'd7) begin
         nerr++; $display("FAIL mismatch_rereq: irq=%0b id=%0d, want 1 7", irq, irq_id);
      end
   endtask

   task automatic test_set_wins_sec();
      do_reset();
      sm = 32'h1 << 7;
      ev = 32'h1 << 7; tick(); ev = 0;
      tick();
      nchk++;
      if (irq !== 1 || irq_sec !== 1) begin
         nerr++; $display("FAIL sec_bit: irq=%0b sec=%0b, want 1 1", irq, irq_sec);
      end
      ev = 32'h1 << 7; ack = 1; ack_id = 5'd7; tick(); ev = 0; ack = 0;
      nchk++;
      if (pend[7] !== 1 || irq !== 0 || irq_sec !== 0 || mis !== 0) begin
         nerr++; $display("FAIL set_wins: p7=%0b irq=%0b sec=%0b mis=%0b, want 1 0 0 0",
                          pend[7], irq, irq_sec, mis);
      end
      tick(); tick();
      nchk++;
      if (irq !== 1 || irq_id !== 5'd7 || irq_sec !== 1) begin
         nerr++; $display("FAIL set_wins_rereq: irq=%0b id=%0d sec=%0b, want 1 7 1", irq, irq_id, irq_sec);
      end
      rst = 1; tick(); rst = 0;
      nchk++;
      if (irq !== 0 || irq_id !== 0 || irq_sec !== 0 || pend !== 0 || mis !== 0) begin
         nerr++; $display("FAIL reset_midreq: irq=%0b id=%0d sec=%0b pend=%h mis=%0b, want all 0",
                          irq, irq_id, irq_sec, pend, mis);
      end
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         r      = $urandom_range(0, 9);
         ev     = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
         en     = ($urandom_range(0, 7) == 0) ? $urandom : 32'hFFFF_FFFF;
         sm     = (c % 64 == 0) ? $urandom : sm;
         ack    = 0;
         ack_id = 0;
         if (m_irq && r < 4) begin
            ack    = 1;
            ack_id = (r == 0) ? 5'($urandom_range(0, 31)) : m_id;
         end else if (!m_irq && r == 9) begin
            ack    = 1;
            ack_id = 5'($urandom_range(0, 31));
         end
         rst = ($urandom_range(0, 299) == 0);
         tick();
         nchk++;
         if (irq !== m_irq || irq_id !== m_id || irq_sec !== m_sec) begin
            nerr++; $display("FAIL rand_req c=%0d: irq=%0b id=%0d sec=%0b, want %0b %0d %0b",
                             c, irq, irq_id, irq_sec, m_irq, m_id, m_sec);
         end
         nchk++;
         if (pend !== m_pend || mis !== m_mis) begin
            nerr++; $display("FAIL rand_pend c=%0d: pend=%h mis=%0b, want %h %0b",
                             c, pend, mis, m_pend, m_mis);
         end
      end
      rst = 0; ack = 0; ev = 0;
   endtask

   initial begin
      rst = 1; ev = 0; en = '1; sm = 0; ack = 0; ack_id = 0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_priority();
      test_rearb();
      test_withdraw();
      test_mismatch();
      test_set_wins_sec();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
